// File: rtl/sr_drive_ctrl.sv
// Command stage for a downstream SR flip-flop: issues exclusive s/r pulses,
// then confirms the result through q_fb and flags a sticky error on timeout.
//
// state | meaning
// IDLE  | waiting for set_req / clr_req
// DRIVE | s or r asserted for HOLD_CYCLES cycles
// CHECK | waiting up to FB_TIMEOUT cycles for q_fb == target
// FAULT | feedback never matched; err held until err_clr
module sr_drive_ctrl #(
  parameter int HOLD_CYCLES  = 1,
  parameter int FB_TIMEOUT   = 4,
  parameter int PRIORITY_CLR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_req,
  input  logic       clr_req,
  input  logic       err_clr,
  input  logic       q_fb,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] TMO_LD  = 4'(FB_TIMEOUT - 1);
  localparam logic       SET_WINS_TIE = (PRIORITY_CLR == 0);

  state_t     state;
  logic       target;
  logic [3:0] tmr;
  logic       pick_set;

  // On a simultaneous request the losing one is simply dropped.
  assign pick_set = set_req & (~clr_req | SET_WINS_TIE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target   <= 1'b0;
      tmr      <= 4'd0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_count <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (set_req | clr_req) begin
            target <= pick_set;
            s      <= pick_set;
            r      <= ~pick_set;
            busy   <= 1'b1;
            tmr    <= HOLD_LD;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (tmr == 4'd0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            tmr   <= TMO_LD;
            state <= CHECK;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        CHECK: begin
          // A match on the last allowed cycle still counts as success.
          if (q_fb == target) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            op_count <= op_count + 8'd1;
            state    <= IDLE;
          end else if (tmr == 4'd0) begin
            err   <= 1'b1;
            state <= FAULT;
          end else begin
            tmr <= tmr - 4'd1;
          end
        end
        FAULT: begin
          if (err_clr) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
